// File: rtl/serial_tx.sv
// Framed bit-serial transmitter: start bit, DATA_W data bits LSB first, stop bit.
// The serial outputs are registered from the FSM state, so they trail it by one cycle.
module serial_tx #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              dout,
    output logic              busy,
    output logic              done
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                dout_q, dout_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                bit_end;
    logic                accept;

    assign din_ready = (state_q == StIdle) && !rst;
    assign accept    = din_valid && din_ready;
    assign bit_end   = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        unique case (state_q)
            StIdle: begin
                baud_d = '0;
                bit_d  = '0;
                if (accept) begin
                    shift_d = din;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StData: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = StIdle;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // busy_q still high in the first IDLE cycle marks the end of a completed frame.
    always_comb begin
        dout_d = 1'b1;
        busy_d = (state_q != StIdle);
        done_d = (state_q == StIdle) && busy_q;
        unique case (state_q)
            StStart: dout_d = 1'b0;
            StData:  dout_d = shift_q[0];
            default: dout_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            dout_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign dout = dout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: a default (8 bits, 4 clocks/bit) instance and a
// minimal (1 bit, 1 clock/bit) instance, both checked against a frame-level model.
module tb_serial_tx;

    logic       clk;
    logic       rst;
    logic [7:0] m_din;
    logic       m_valid, m_ready, m_dout, m_busy, m_done;
    logic [0:0] e_din;
    logic       e_valid, e_ready, e_dout, e_busy, e_done;

    int n_checks = 0;
    int n_fail   = 0;

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .din       (m_din),
        .din_valid (m_valid),
        .din_ready (m_ready),
        .dout      (m_dout),
        .busy      (m_busy),
        .done      (m_done)
    );

    serial_tx #(.DATA_W(1), .CLKS_PER_BIT(1)) u_dut_min (
        .clk       (clk),
        .rst       (rst),
        .din       (e_din),
        .din_valid (e_valid),
        .din_ready (e_ready),
        .dout      (e_dout),
        .busy      (e_busy),
        .done      (e_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a word for exactly one edge (the accept edge); returns #1 after it.
    task automatic start_frame(input bit sel, input logic [7:0] word);
        if (sel) begin
            e_din   = word[0];
            e_valid = 1'b1;
        end else begin
            m_din   = word;
            m_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        if (sel) e_valid = 1'b0;
        else     m_valid = 1'b0;
    endtask

    // Called #1 after the accept edge. Checks every cycle of the frame and the done cycle.
    task automatic check_frame(input bit sel, input logic [7:0] word, input string name);
        int   w;
        int   c;
        int   len;
        int   j;
        logic exp_d, exp_b, exp_n;
        logic obs_d, obs_b, obs_n;
        w   = sel ? 1 : 8;
        c   = sel ? 1 : 4;
        len = (w + 2) * c;
        for (int t = 1; t <= len + 1; t++) begin
            @(posedge clk);
            #1;
            if (t <= len) begin
                j = (t - 1) / c;
                if (j == 0)      exp_d = 1'b0;
                else if (j <= w) exp_d = word[j-1];
                else             exp_d = 1'b1;
            end else begin
                exp_d = 1'b1;
            end
            exp_b = (t <= len);
            exp_n = (t == len + 1);
            obs_d = sel ? e_dout : m_dout;
            obs_b = sel ? e_busy : m_busy;
            obs_n = sel ? e_done : m_done;
            n_checks++;
            if (obs_d !== exp_d) begin
                n_fail++;
                $display("FAIL %s dout cycle %0d: got %b expected %b", name, t, obs_d, exp_d);
            end
            n_checks++;
            if (obs_b !== exp_b) begin
                n_fail++;
                $display("FAIL %s busy cycle %0d: got %b expected %b", name, t, obs_b, exp_b);
            end
            n_checks++;
            if (obs_n !== exp_n) begin
                n_fail++;
                $display("FAIL %s done cycle %0d: got %b expected %b", name, t, obs_n, exp_n);
            end
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        m_valid = 1'b1;
        e_valid = 1'b1;
        m_din   = 8'h5A;
        e_din   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({m_dout, m_busy, m_done, m_ready, e_ready} !== 5'b10000) begin
                n_fail++;
                $display("FAIL reset cycle %0d: dout/busy/done/ready/ready_min got %b expected 10000",
                         i, {m_dout, m_busy, m_done, m_ready, e_ready});
            end
        end
        rst     = 1'b0;
        m_valid = 1'b0;
        e_valid = 1'b0;
        #1;
        n_checks++;
        if ({m_ready, e_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_release ready: got %b expected 11", {m_ready, e_ready});
        end
    endtask

    task automatic test_single_frame();
        start_frame(1'b0, 8'hA5);
        check_frame(1'b0, 8'hA5, "single_a5");
        @(posedge clk);
        #1;
        n_checks++;
        if ({m_done, m_ready, m_dout} !== 3'b011) begin
            n_fail++;
            $display("FAIL single_after done/ready/dout: got %b expected 011",
                     {m_done, m_ready, m_dout});
        end
    endtask

    task automatic test_data_stability();
        start_frame(1'b0, 8'h3C);
        m_din = 8'hFF;
        check_frame(1'b0, 8'h3C, "stable_3c");
    endtask

    task automatic test_back_to_back();
        m_din   = 8'h01;
        m_valid = 1'b1;
        @(posedge clk);
        #1;
        m_din = 8'h80;
        // valid stays high through the first frame; second accept lands on the done cycle
        check_frame(1'b0, 8'h01, "b2b_first");
        m_valid = 1'b0;
        n_checks++;
        if (m_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second_accept ready: got %b expected 0", m_ready);
        end
        check_frame(1'b0, 8'h80, "b2b_second");
    endtask

    task automatic test_reset_mid_frame();
        start_frame(1'b0, 8'h00);
        repeat (1 + 4 * 4 + 1) @(posedge clk);
        #1;
        n_checks++;
        if ({m_dout, m_busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL midreset_bit3 dout/busy: got %b expected 01", {m_dout, m_busy});
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if ({m_dout, m_busy, m_done} !== 3'b100) begin
            n_fail++;
            $display("FAIL midreset_after dout/busy/done: got %b expected 100",
                     {m_dout, m_busy, m_done});
        end
        for (int i = 0; i < 42; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({m_dout, m_done} !== 2'b10) begin
                n_fail++;
                $display("FAIL midreset_quiet cycle %0d dout/done: got %b expected 10",
                         i, {m_dout, m_done});
            end
        end
        start_frame(1'b0, 8'hFF);
        check_frame(1'b0, 8'hFF, "midreset_ff");
    endtask

    task automatic test_edge_params();
        start_frame(1'b1, 8'h01);
        check_frame(1'b1, 8'h01, "min_one");
        start_frame(1'b1, 8'h00);
        check_frame(1'b1, 8'h00, "min_zero");
    endtask

    task automatic test_random();
        logic [7:0] w;
        int         gap;
        for (int i = 0; i < 8; i++) begin
            w   = 8'($urandom_range(0, 255));
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            start_frame(1'b0, w);
            if ($urandom_range(0, 1) == 1) m_din = ~w;
            check_frame(1'b0, w, "random");
        end
        for (int i = 0; i < 6; i++) begin
            w = 8'($urandom_range(0, 1));
            start_frame(1'b1, w);
            check_frame(1'b1, w, "random_min");
        end
    endtask

    initial begin
        rst     = 1'b1;
        m_valid = 1'b0;
        e_valid = 1'b0;
        m_din   = '0;
        e_din   = '0;
        test_reset();
        test_single_frame();
        test_data_stability();
        test_back_to_back();
        test_reset_mid_frame();
        test_edge_params();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
